iod_delay_tap_ctrl: RTL and testbench
=====================================

// Module: iod_delay_tap_ctrl
// PURPOSE
//  Sequences the dynamic delay-line controls (DELAY_LINE_MOVE/DIRECTION/LOAD) of one PF IOD lane.
//  It is the lane-side controller for DDR3 address/command IODs such as WE_N.
//  Accepts a target tap over a valid/ready handshake, optionally reloads the line to its
//  static value, then steps it one tap at a time, tracking position and trapping out-of-range.
// PARAMETERS
//  TAP_W      8    width of tap counter / requested tap
//  MAX_TAP    255  highest legal tap; requests above are rejected
//  INIT_TAP   1    tap value after DELAY_LINE_LOAD (matches IOD TX_DELAY_VAL)
//  MOVE_GAP   3    idle cycles after each MOVE pulse before next pulse/OOR sample (>=1)
// PORTS
//  FAB_CLK                    in   1      fabric clock; all logic rising-edge
//  SYNC_RST_N                 in   1      synchronous reset, active low
//  REQ_VALID                  in   1      request valid
//  REQ_READY                  out  1      controller can accept (IDLE only)
//  REQ_LOAD                   in   1      1 = pulse DELAY_LINE_LOAD before stepping
//  REQ_TAP                    in   TAP_W  target tap
//  DONE                       out  1      1-cycle pulse, request finished (ok or error)
//  ERR                        out  1      valid with DONE: 1 = rejected or out-of-range abort
//  BUSY                       out  1      1 while not IDLE
//  CUR_TAP                    out  TAP_W  controller's model of current tap
//  DELAY_LINE_MOVE            out  1      to IOD DELAY_LINE_MOVE_0
//  DELAY_LINE_DIRECTION       out  1      to IOD; 1 = increment, 0 = decrement
//  DELAY_LINE_LOAD            out  1      to IOD DELAY_LINE_LOAD_0
//  DELAY_LINE_OUT_OF_RANGE    in   1      from IOD DELAY_LINE_OUT_OF_RANGE_0
// BEHAVIOUR
//  Reset (SYNC_RST_N=0 at edge): state=IDLE, CUR_TAP=INIT_TAP, REQ_READY=1, DONE=0, ERR=0,
//   BUSY=0, MOVE=0, LOAD=0, DIRECTION=1; mid-operation reset abandons request, no DONE.
//  Accept = REQ_VALID & REQ_READY; REQ_TAP/REQ_LOAD captured at that edge; READY=0 until IDLE.
//  States: IDLE, LOAD, LWAIT, SETUP, MOVE, GAP, FIN.
//  IDLE: on accept -> REQ_TAP>MAX_TAP ? FIN(err) : REQ_LOAD ? LOAD : SETUP.
//  LOAD: DELAY_LINE_LOAD=1 for exactly 1 cycle; CUR_TAP<=INIT_TAP -> LWAIT.
//  LWAIT: MOVE_GAP cycles idle -> SETUP.
//  SETUP (1 cycle): target==CUR_TAP -> FIN(ok); else DIRECTION<=(target>CUR_TAP), -> MOVE.
//   DIRECTION is stable >=1 cycle before and throughout every MOVE pulse.
//  MOVE: DELAY_LINE_MOVE=1 for 1 cycle; CUR_TAP +/-1 (TAP_W wide, no wrap by construction) -> GAP.
//  GAP: MOVE_GAP cycles; OOR sampled in last GAP cycle: 1 -> undo CUR_TAP step, FIN(err);
//   else CUR_TAP==target -> FIN(ok), otherwise -> MOVE.
//  FIN: DONE=1, ERR per outcome, one cycle -> IDLE (READY=1 next cycle).
//  Reject path: no LOAD/MOVE pulses, CUR_TAP unchanged, DONE at 2nd edge after accept.
//  Latency accept->DONE (no load, |d| steps): 2 + |d|*(1+MOVE_GAP) cycles; load adds 1+MOVE_GAP.
//  MOVE and LOAD are never asserted in the same cycle; at most one MOVE per 1+MOVE_GAP cycles.
//  OOR asserted outside GAP sampling is ignored. REQ_VALID while BUSY is held off (READY=0).
//  ERR holds its value until next DONE; CUR_TAP only changes in LOAD, MOVE or GAP-undo.
// TESTING
//  Reset, then REQ_TAP=5, no load -> 4 MOVE pulses, DIRECTION=1, CUR_TAP=5, DONE@2+4*4=18, ERR=0.
//  From tap 5, REQ_TAP=2, REQ_LOAD=1 -> one LOAD pulse, CUR_TAP=1, then 1 inc MOVE, DONE, ERR=0.
//  From tap 5, REQ_TAP=3 -> DIRECTION=0 set in SETUP before first MOVE, 2 MOVEs, CUR_TAP=3.
//  REQ_TAP=CUR_TAP -> zero MOVE pulses, DONE 2 cycles after accept, ERR=0.
//  MAX_TAP=100, REQ_TAP=200 -> no pulses, DONE+ERR=1, CUR_TAP unchanged.
//  Force OOR=1 in the 3rd step's GAP -> DONE+ERR=1, CUR_TAP=start+2; reset during MOVE -> reset values.

Source files
------------

// File: rtl/iod_delay_tap_ctrl.sv
// Lane-side sequencer for a PF IOD dynamic delay line.
// Takes a target tap over valid/ready, optionally reloads the line to its
// static value, then steps one tap per MOVE pulse with a settle gap after
// each pulse, tracking the tap position and aborting on out-of-range.
// Every output is a register loaded from the next-state decode, so each
// pulse is high exactly during the cycle its state occupies.
// A rejected target is routed through SETUP so that its DONE lands on the
// same cycle as a zero-step request.
module iod_delay_tap_ctrl #(
  parameter int TAP_W    = 8,
  parameter int MAX_TAP  = 255,
  parameter int INIT_TAP = 1,
  parameter int MOVE_GAP = 3
) (
  input  logic             fab_clk,
  input  logic             sync_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic [TAP_W-1:0] req_tap,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [TAP_W-1:0] cur_tap,
  output logic             delay_line_move,
  output logic             delay_line_direction,
  output logic             delay_line_load,
  input  logic             delay_line_out_of_range
);

  localparam int                GAP_W    = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(MOVE_GAP - 1);
  localparam logic [GAP_W-1:0]  GAP_ZERO = GAP_W'(0);
  localparam logic [TAP_W:0]    MAX_L    = (TAP_W + 1)'(MAX_TAP);
  localparam logic [TAP_W-1:0]  INIT_L   = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0]  STEP_L   = TAP_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_LWAIT = 3'd2,
    ST_SETUP = 3'd3,
    ST_MOVE  = 3'd4,
    ST_GAP   = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  state_t             state_r, state_n;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_n;
  logic [TAP_W-1:0]   cur_tap_r, cur_tap_n;
  logic [TAP_W-1:0]   target_r, target_n;
  logic               rej_r, rej_n;
  logic               direction_r, direction_n;
  logic               err_r, err_n;
  logic               done_r, move_r, load_r, busy_r, req_ready_r;
  logic               accept_s, bad_tap_s;
  logic [TAP_W-1:0]   tgt_s;
  logic               rej_s;

  assign accept_s  = req_valid & req_ready_r & (state_r == ST_IDLE);
  assign bad_tap_s = ({1'b0, req_tap} > MAX_L);
  // The target/reject seen on the accept edge comes straight from the request.
  assign tgt_s     = (state_r == ST_IDLE) ? req_tap : target_r;
  assign rej_s     = (state_r == ST_IDLE) ? bad_tap_s : rej_r;

  // Next-state, tap tracking and outcome decode.
  always_comb begin
    state_n     = state_r;
    gap_cnt_n   = gap_cnt_r;
    cur_tap_n   = cur_tap_r;
    target_n    = target_r;
    rej_n       = rej_r;
    err_n       = err_r;
    direction_n = direction_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          target_n = req_tap;
          rej_n    = bad_tap_s;
          if (req_load && !bad_tap_s) begin
            state_n = ST_LOAD;
          end else begin
            state_n = ST_SETUP;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cur_tap_n = INIT_L;
        gap_cnt_n = GAP_ZERO;
        state_n   = ST_LWAIT;
      end
      ST_LWAIT: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_n = ST_SETUP;
        end else begin
          gap_cnt_n = gap_cnt_r + GAP_W'(1);
        end
      end
      ST_SETUP: begin
        if (rej_r) begin
          err_n   = 1'b1;
          state_n = ST_FIN;
        end else if (target_r == cur_tap_r) begin
          err_n   = 1'b0;
          state_n = ST_FIN;
        end else begin
          state_n = ST_MOVE;
        end
      end
      ST_MOVE: begin
        cur_tap_n = direction_r ? (cur_tap_r + STEP_L) : (cur_tap_r - STEP_L);
        gap_cnt_n = GAP_ZERO;
        state_n   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_r != GAP_LAST) begin
          gap_cnt_n = gap_cnt_r + GAP_W'(1);
        end else if (delay_line_out_of_range) begin
          // The line refused the last step: take it back out of the model.
          cur_tap_n = direction_r ? (cur_tap_r - STEP_L) : (cur_tap_r + STEP_L);
          err_n     = 1'b1;
          state_n   = ST_FIN;
        end else if (cur_tap_r == target_r) begin
          err_n   = 1'b0;
          state_n = ST_FIN;
        end else begin
          state_n = ST_MOVE;
        end
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // Direction settles on SETUP entry, a full cycle ahead of the first MOVE.
    if ((state_n == ST_SETUP) && !rej_s) begin
      direction_n = (tgt_s > cur_tap_n);
    end else begin
      direction_n = direction_r;
    end
  end

  // State, datapath and registered output update with synchronous reset.
  always_ff @(posedge fab_clk) begin
    if (!sync_rst_n) begin
      state_r     <= ST_IDLE;
      gap_cnt_r   <= GAP_ZERO;
      cur_tap_r   <= INIT_L;
      target_r    <= INIT_L;
      rej_r       <= 1'b0;
      direction_r <= 1'b1;
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      move_r      <= 1'b0;
      load_r      <= 1'b0;
      busy_r      <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_n;
      gap_cnt_r   <= gap_cnt_n;
      cur_tap_r   <= cur_tap_n;
      target_r    <= target_n;
      rej_r       <= rej_n;
      direction_r <= direction_n;
      err_r       <= err_n;
      done_r      <= (state_n == ST_FIN);
      move_r      <= (state_n == ST_MOVE);
      load_r      <= (state_n == ST_LOAD);
      busy_r      <= (state_n != ST_IDLE);
      req_ready_r <= (state_n == ST_IDLE);
    end
  end

  assign req_ready            = req_ready_r;
  assign done                 = done_r;
  assign err                  = err_r;
  assign busy                 = busy_r;
  assign cur_tap              = cur_tap_r;
  assign delay_line_move      = move_r;
  assign delay_line_direction = direction_r;
  assign delay_line_load      = load_r;

endmodule

// File: tb/tb_iod_delay_tap_ctrl.sv
// Scoreboard bench for iod_delay_tap_ctrl (MAX_TAP=100, INIT_TAP=1, MOVE_GAP=3).
// Stimulus pushes the hand-computed outcome of each request; the monitor
// measures pulses/latency per request and compares when DONE appears.
// Latency = number of rising edges from the accept edge up to and including
// the edge that samples DONE high.
module tb_iod_delay_tap_ctrl;

  typedef struct {
    int err;
    int tap;
    int lat;
    int moves;
    int loads;
    int dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       sync_rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_load;
  logic [7:0] req_tap;
  logic       done;
  logic       err;
  logic       busy;
  logic [7:0] cur_tap;
  logic       dl_move;
  logic       dl_dir;
  logic       dl_load;
  logic       oor = 1'b0;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   tmo_req = 0;
  int   tmo_seen = 0;
  logic oor_arm = 1'b0;

  always #5 clk = ~clk;

  iod_delay_tap_ctrl #(
    .TAP_W(8), .MAX_TAP(100), .INIT_TAP(1), .MOVE_GAP(3)
  ) dut (
    .fab_clk                 (clk),
    .sync_rst_n              (sync_rst_n),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_load                (req_load),
    .req_tap                 (req_tap),
    .done                    (done),
    .err                     (err),
    .busy                    (busy),
    .cur_tap                 (cur_tap),
    .delay_line_move         (dl_move),
    .delay_line_direction    (dl_dir),
    .delay_line_load         (dl_load),
    .delay_line_out_of_range (oor)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: reset-value checks, per-request measurement, scoreboard compare.
  int   active = 0;
  int   cyc = 0;
  int   mv = 0;
  int   ld = 0;
  int   dir_bad = 0;
  int   ovl = 0;
  logic prev_dir = 1'b1;
  always @(posedge clk) begin
    logic acc_s;
    logic rst_s;
    exp_t e;
    acc_s = sync_rst_n && req_valid && req_ready;
    rst_s = sync_rst_n;
    #1;
    if (!rst_s) begin
      active = 0;
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_busy",  int'(busy), 0);
      chk("rst_done",  int'(done), 0);
      chk("rst_err",   int'(err), 0);
      chk("rst_move",  int'(dl_move), 0);
      chk("rst_load",  int'(dl_load), 0);
      chk("rst_dir",   int'(dl_dir), 1);
      chk("rst_tap",   int'(cur_tap), 1);
    end else begin
      if (acc_s) begin
        active = 1; cyc = 0; mv = 0; ld = 0; dir_bad = 0; ovl = 0;
      end else if (active != 0) begin
        cyc++;
      end
      if (dl_move && dl_load) ovl = 1;
      if (dl_move) begin
        mv++;
        if (exp_q.size() > 0) begin
          if (int'(dl_dir) != exp_q[0].dir || dl_dir != prev_dir) dir_bad = 1;
        end
      end
      if (dl_load) ld++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("err",     int'(err), e.err);
          chk("cur_tap", int'(cur_tap), e.tap);
          chk("latency", cyc + 1, e.lat);
          chk("moves",   mv, e.moves);
          chk("loads",   ld, e.loads);
          chk("move_load_overlap", ovl, 0);
          if (e.moves > 0) chk("direction", dir_bad, 0);
        end
        active = 0;
      end
    end
    prev_dir = dl_dir;
    if (tmo_req != tmo_seen) begin
      chk("timeout", 1, 0);
      tmo_seen = tmo_req;
    end
  end

  // Out-of-range injector: holds OOR across the GAP after the 3rd MOVE.
  int inj_mv = 0;
  int oor_hold = 0;
  always @(negedge clk) begin
    if (oor_hold > 0) begin
      oor_hold--;
      if (oor_hold == 0) oor = 1'b0;
    end else if (oor_arm && dl_move) begin
      inj_mv++;
      if (inj_mv == 3) begin
        oor = 1'b1;
        oor_hold = 4;
      end
    end else if (!oor_arm) begin
      inj_mv = 0;
    end
  end

  task automatic send(input logic [7:0] tap, input logic load);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) tmo_req++;
    req_valid = 1'b1;
    req_tap   = tap;
    req_load  = load;
    @(negedge clk);
    req_valid = 1'b0;
    req_load  = 1'b0;
  endtask

  task automatic issue(input logic [7:0] tap, input logic load, input exp_t e);
    int n;
    exp_q.push_back(e);
    send(tap, load);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tmo_req++;
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    sync_rst_n = 1'b0;
    req_valid  = 1'b0;
    req_load   = 1'b0;
    req_tap    = 8'd0;
    repeat (3) @(negedge clk);
    sync_rst_n = 1'b1;
    @(negedge clk);

    // err, tap, latency, moves, loads, direction
    issue(8'd5,   1'b0, '{0, 5, 18, 4, 0, 1});   // 1 -> 5, four increments
    issue(8'd2,   1'b1, '{0, 2, 10, 1, 1, 1});   // reload to 1, one increment
    issue(8'd5,   1'b0, '{0, 5, 14, 3, 0, 1});   // 2 -> 5
    issue(8'd3,   1'b0, '{0, 3, 10, 2, 0, 0});   // 5 -> 3, decrement
    issue(8'd3,   1'b0, '{0, 3, 2, 0, 0, 0});    // already there
    issue(8'd200, 1'b0, '{1, 3, 2, 0, 0, 1});    // above MAX_TAP: rejected
    oor_arm = 1'b1;
    issue(8'd8,   1'b0, '{1, 5, 14, 3, 0, 1});   // OOR on 3rd step: 3+2
    oor_arm = 1'b0;

    // Reset in the middle of a move sequence: no DONE, reset values return.
    send(8'd10, 1'b0);
    n = 0;
    while (!dl_move && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dl_move) tmo_req++;
    sync_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sync_rst_n = 1'b1;
    @(negedge clk);

    issue(8'd2,   1'b0, '{0, 2, 6, 1, 0, 1});    // 1 -> 2 after reset
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
